// File: rtl/window_ram_pkg.sv
// Shared types and default sizing for the window_ram block and its address generator.
package window_ram_pkg;

    localparam int DWIDTH_DEF = 16;
    localparam int AWIDTH_DEF = 8;
    localparam int TAPS_DEF   = 16;
    localparam int LWIDTH_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/window_ram_agen.sv
// Read sequencer: walks window base addresses by stride and runs the valid/ready output slot.
module window_ram_agen
    import window_ram_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int LWIDTH = LWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [AWIDTH-1:0] rd_base,
    input  logic [AWIDTH-1:0] rd_stride,
    input  logic [LWIDTH-1:0] rd_len,
    input  logic              dout_ready,
    output logic              load,
    output logic [AWIDTH-1:0] base,
    output logic              rd_busy,
    output logic              dout_valid,
    output logic              dout_last
);

    state_t            state;
    logic [AWIDTH-1:0] ptr;
    logic [AWIDTH-1:0] stride;
    logic [LWIDTH-1:0] rem;

    // A new window may enter the output slot when it is empty or being drained this cycle.
    assign load    = (state == RUN) && (rem != '0) && (!dout_valid || dout_ready);
    assign base    = ptr;
    assign rd_busy = (state == RUN);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            stride     <= '0;
            rem        <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req && (rd_len != '0)) begin
                        state  <= RUN;
                        ptr    <= rd_base;
                        stride <= rd_stride;
                        rem    <= rd_len;
                    end
                end
                RUN: begin
                    if (load) begin
                        dout_valid <= 1'b1;
                        dout_last  <= (rem == LWIDTH'(1));
                        ptr        <= ptr + stride;
                        rem        <= rem - LWIDTH'(1);
                    end else if (dout_valid && dout_ready && dout_last) begin
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/window_ram.sv
// Multi-tap window-read RAM: one write port, TAPS-wide window reads driven by window_ram_agen.
module window_ram
    import window_ram_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int TAPS   = TAPS_DEF,
    parameter int LWIDTH = LWIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [AWIDTH-1:0]      wr_addr,
    input  logic [DWIDTH-1:0]      wr_data,
    input  logic                   rd_req,
    input  logic [AWIDTH-1:0]      rd_base,
    input  logic [AWIDTH-1:0]      rd_stride,
    input  logic [LWIDTH-1:0]      rd_len,
    output logic                   rd_busy,
    output logic [TAPS*DWIDTH-1:0] dout,
    output logic                   dout_valid,
    output logic                   dout_last,
    input  logic                   dout_ready
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] tap_addr [TAPS];
    logic              load;
    logic [AWIDTH-1:0] base;

    window_ram_agen #(
        .AWIDTH(AWIDTH),
        .LWIDTH(LWIDTH)
    ) u_agen (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_req    (rd_req),
        .rd_base   (rd_base),
        .rd_stride (rd_stride),
        .rd_len    (rd_len),
        .dout_ready(dout_ready),
        .load      (load),
        .base      (base),
        .rd_busy   (rd_busy),
        .dout_valid(dout_valid),
        .dout_last (dout_last)
    );

    // Tap addresses wrap at the top of the array, so a window may straddle 2^AWIDTH-1 -> 0.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            tap_addr[k] = base + AWIDTH'(k);
        end
    end

    // NOTE: the storage array has no reset; clearing it would need a per-word reset mux and contents are undefined until written anyway.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Loading at the same edge as a write samples the pre-write word (read-before-write).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (load) begin
            for (int k = 0; k < TAPS; k++) begin
                dout[k*DWIDTH +: DWIDTH] <= mem[tap_addr[k]];
            end
        end
    end

endmodule

// File: tb/tb_window_ram.sv
// Self-checking bench for window_ram: table-driven commands against a shadow-memory scoreboard.
module tb_window_ram;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int TP = 16;
    localparam int LW = 8;
    localparam int WW = TP * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_req;
    logic [AW-1:0] rd_base;
    logic [AW-1:0] rd_stride;
    logic [LW-1:0] rd_len;
    logic          rd_busy;
    logic [WW-1:0] dout;
    logic          dout_valid;
    logic          dout_last;
    logic          dout_ready;

    window_ram #(.DWIDTH(DW), .AWIDTH(AW), .TAPS(TP), .LWIDTH(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_base   (rd_base),
        .rd_stride (rd_stride),
        .rd_len    (rd_len),
        .rd_busy   (rd_busy),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_last (dout_last),
        .dout_ready(dout_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] stride;
        logic [LW-1:0] len;
        int            bp;        // 0: always ready, 1: random ready, 2: three stalls on first window
        bit            poke;      // issue a stray rd_req mid-command
        int            exp_n;
        logic [DW-1:0] exp_last_tap0;
    } vec_t;

    exp_t          sb[$];
    logic [DW-1:0] shadow [1 << AW];
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WW-1:0] model_win(input logic [AW-1:0] b);
        logic [WW-1:0] w;
        logic [AW-1:0] a;
        for (int k = 0; k < TP; k++) begin
            a = b + AW'(k);
            w[k*DW +: DW] = shadow[a];
        end
        return w;
    endfunction

    task automatic push_cmd(input logic [AW-1:0] base, input logic [AW-1:0] stride, input logic [LW-1:0] len);
        logic [AW-1:0] b;
        exp_t          e;
        b = base;
        for (int j = 0; j < int'(len); j++) begin
            e.data = model_win(b);
            e.last = (j == int'(len) - 1);
            sb.push_back(e);
            b = b + stride;
        end
    endtask

    task automatic take_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: got unexpected window expected none", name);
        end else begin
            e = sb.pop_front();
            check({name, "_data"}, dout, e.data);
            check({name, "_last"}, WW'(dout_last), WW'(e.last));
        end
    endtask

    task automatic mem_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en     = 1'b0;
        shadow[a] = d;
    endtask

    task automatic run_cmd(input vec_t v, output int n_got, output logic [DW-1:0] last_tap0);
        logic [WW-1:0] held;
        logic          held_last = 1'b0;
        bit            was_stalled = 0;
        bit            done = 0;
        int            stalls = 0;
        int            valid_cycles = 0;
        int            first_it = -1;
        int            budget;
        n_got     = 0;
        last_tap0 = '0;
        held      = '0;
        budget    = (v.len == '0) ? 6 : 400;

        rd_req    = 1'b1;
        rd_base   = v.base;
        rd_stride = v.stride;
        rd_len    = v.len;
        if (v.len != '0) push_cmd(v.base, v.stride, v.len);
        tick();
        rd_req = 1'b0;
        check("busy_after_req", WW'(rd_busy), WW'(v.len != '0));

        for (int it = 0; it < budget && !done; it++) begin
            case (v.bp)
                0:       dout_ready = 1'b1;
                1:       dout_ready = 1'($urandom_range(0, 1));
                default: dout_ready = !(dout_valid && stalls < 3);
            endcase
            if (v.poke && it == 3) begin
                rd_req    = 1'b1;
                rd_base   = 8'h33;
                rd_stride = 8'h01;
                rd_len    = 8'd5;
            end
            if (was_stalled) begin
                check("hold_data", dout, held);
                check("hold_last", WW'(dout_last), WW'(held_last));
            end
            if (dout_valid) begin
                valid_cycles++;
                if (first_it < 0) first_it = it;
            end
            if (dout_valid && !dout_ready) begin
                stalls++;
                was_stalled = 1;
                held        = dout;
                held_last   = dout_last;
            end else begin
                was_stalled = 0;
            end
            if (dout_valid && dout_ready) begin
                take_check("win");
                n_got++;
                last_tap0 = dout[DW-1:0];
                done      = dout_last;
            end
            tick();
            rd_req = 1'b0;
        end
        dout_ready = 1'b0;

        if (v.len != '0 && !done) begin
            tests++;
            fails++;
            $display("FAIL cmd_timeout: got %0d windows expected %0d", n_got, v.len);
        end
        if (v.len == '0) check("len0_no_valid", WW'(valid_cycles), WW'(0));
        if (v.bp == 0 && v.len != '0) begin
            check("first_valid_latency", WW'(first_it), WW'(1));
            check("valid_run_len", WW'(valid_cycles), WW'(v.len));
        end
        if (v.bp == 2) check("stall_cycles", WW'(stalls), WW'(3));
        check("busy_after_cmd", WW'(rd_busy), WW'(0));
        check("valid_after_cmd", WW'(dout_valid), WW'(0));
        check("sb_empty", WW'(sb.size()), WW'(0));
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t          vecs [9];
        vec_t          v;
        int            n;
        logic [DW-1:0] lt;

        vecs[0] = '{8'd0,    8'd16,  8'd16, 0, 0, 16, 16'd240};
        vecs[1] = '{8'd250,  8'd1,   8'd2,  0, 0, 2,  16'd251};
        vecs[2] = '{8'd0,    8'd1,   8'd4,  2, 0, 4,  16'd3};
        vecs[3] = '{8'h80,   8'd0,   8'd3,  0, 0, 3,  16'h80};
        vecs[4] = '{8'd10,   8'd100, 8'd5,  1, 0, 5,  16'd154};
        vecs[5] = '{8'd0,    8'd0,   8'd0,  0, 0, 0,  16'd0};
        vecs[6] = '{8'd255,  8'd255, 8'd4,  1, 0, 4,  16'd252};
        vecs[7] = '{8'h40,   8'd2,   8'd6,  0, 1, 6,  16'h4a};
        vecs[8] = '{8'd3,    8'd5,   8'd3,  0, 0, 3,  16'd13};

        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rd_req     = 1'b0;
        rd_base    = '0;
        rd_stride  = '0;
        rd_len     = '0;
        dout_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", WW'(rd_busy), WW'(0));
        check("rst_valid", WW'(dout_valid), WW'(0));
        check("rst_last", WW'(dout_last), WW'(0));
        check("rst_dout", dout, '0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < (1 << AW); i++) mem_write(AW'(i), DW'(i));

        for (int t = 0; t < 8; t++) begin
            v = vecs[t];
            run_cmd(v, n, lt);
            check("n_windows", WW'(n), WW'(v.exp_n));
            if (v.exp_n > 0) check("last_tap0", WW'(lt), WW'(v.exp_last_tap0));
        end

        // Read-during-write: the window loaded at the write edge must see the old word.
        rd_req    = 1'b1;
        rd_base   = 8'd0;
        rd_stride = 8'd0;
        rd_len    = 8'd2;
        tick();
        rd_req     = 1'b0;
        wr_en      = 1'b1;
        wr_addr    = 8'd5;
        wr_data    = 16'hBEEF;
        dout_ready = 1'b1;
        tick();
        wr_en     = 1'b0;
        shadow[5] = 16'hBEEF;
        check("rdw_valid0", WW'(dout_valid), WW'(1));
        check("rdw_old", WW'(dout[5*DW +: DW]), WW'(16'd5));
        tick();
        check("rdw_valid1", WW'(dout_valid), WW'(1));
        check("rdw_new", WW'(dout[5*DW +: DW]), WW'(16'hBEEF));
        check("rdw_last", WW'(dout_last), WW'(1));
        tick();
        dout_ready = 1'b0;
        check("rdw_busy_done", WW'(rd_busy), WW'(0));

        // Reset mid-command after two of eight windows.
        rd_req    = 1'b1;
        rd_base   = 8'd0;
        rd_stride = 8'd8;
        rd_len    = 8'd8;
        push_cmd(8'd0, 8'd8, 8'd8);
        tick();
        rd_req     = 1'b0;
        dout_ready = 1'b1;
        tick();
        take_check("rst_w0");
        tick();
        take_check("rst_w1");
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_valid", WW'(dout_valid), WW'(0));
        check("midrst_busy", WW'(rd_busy), WW'(0));
        check("midrst_dout", dout, '0);
        rst_n      = 1'b1;
        dout_ready = 1'b0;
        sb.delete();
        tick();

        v = vecs[8];
        run_cmd(v, n, lt);
        check("post_rst_n", WW'(n), WW'(v.exp_n));
        check("post_rst_last_tap0", WW'(lt), WW'(v.exp_last_tap0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
